// File: rtl/game_pkg.sv
// Shared types and defaults for the tank game round controller.
// States, winner codes and parameter defaults live here.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RESPAWN = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_T1   = 2'b01;
  localparam logic [1:0] WIN_T2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [7:0] START_KEY_DEF = 8'h28;
  localparam int unsigned WIN_SCORE_DEF = 5;
  localparam int unsigned RESPAWN_FRAMES_DEF = 8;

  function automatic logic [1:0] winner_of(
    input logic t1_won,
    input logic t2_won
  );
    logic [1:0] w;
    w = WIN_NONE;
    unique case (1'b1)
      (t1_won & t2_won): w = WIN_DRAW;
      (t1_won & ~t2_won): w = WIN_T1;
      (~t1_won & t2_won): w = WIN_T2;
      default: w = WIN_NONE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Keyboard/collision inputs and round status outputs of the
// round controller, bundled for the top-level port.
interface game_round_ctrl_if;
  import game_pkg::*;

  logic [7:0] keycode;
  logic       Bullet2_Tank1_intersect;
  logic       Bullet1_Tank2_intersect;
  logic [1:0] game_state;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       tanks_freeze;
  logic       tank1_respawn;
  logic       tank2_respawn;
  logic       round_reset;

  modport master (
    output keycode,
    output Bullet2_Tank1_intersect,
    output Bullet1_Tank2_intersect,
    input  game_state,
    input  score1,
    input  score2,
    input  winner,
    input  tanks_freeze,
    input  tank1_respawn,
    input  tank2_respawn,
    input  round_reset
  );

  modport slave (
    input  keycode,
    input  Bullet2_Tank1_intersect,
    input  Bullet1_Tank2_intersect,
    output game_state,
    output score1,
    output score2,
    output winner,
    output tanks_freeze,
    output tank1_respawn,
    output tank2_respawn,
    output round_reset
  );

endinterface

// File: rtl/game_round_ctrl_rise_detect.sv
// Rising-edge detector: one pulse when a level goes 0->1.
// History always tracks the input, so reset needs no special case.
module rise_detect (
  input  logic frame_clk,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge frame_clk) begin
    d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: start/score/respawn/game-over sequencing
// for a two-tank game, clocked once per video frame.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE = WIN_SCORE_DEF,
  parameter int unsigned RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter logic [7:0] START_KEY = START_KEY_DEF
) (
  input logic frame_clk,
  input logic Reset,
  game_round_ctrl_if.slave bus
);

  localparam logic [3:0] WS = 4'(WIN_SCORE);
  localparam logic [7:0] RF_LAST = 8'(RESPAWN_FRAMES - 1);

  logic start, hit1, hit2, key_on;

  assign key_on = (bus.keycode == START_KEY);

  rise_detect u_start (
    .frame_clk(frame_clk),
    .d(key_on),
    .rise(start)
  );

  rise_detect u_hit1 (
    .frame_clk(frame_clk),
    .d(bus.Bullet2_Tank1_intersect),
    .rise(hit1)
  );

  rise_detect u_hit2 (
    .frame_clk(frame_clk),
    .d(bus.Bullet1_Tank2_intersect),
    .rise(hit2)
  );

  state_t     state, state_n;
  logic [3:0] s1, s2, s1_n, s2_n, up1, up2;
  logic [1:0] win, win_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] hits, hits_n;
  logic       done1, done2;
  logic       rr, rr_n, rs1, rs1_n, rs2, rs2_n, frz;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
      s1    <= '0;
      s2    <= '0;
      win   <= WIN_NONE;
      cnt   <= '0;
      hits  <= '0;
      rr    <= 1'b0;
      rs1   <= 1'b0;
      rs2   <= 1'b0;
      frz   <= 1'b1;
    end else begin
      state <= state_n;
      s1    <= s1_n;
      s2    <= s2_n;
      win   <= win_n;
      cnt   <= cnt_n;
      hits  <= hits_n;
      rr    <= rr_n;
      rs1   <= rs1_n;
      rs2   <= rs2_n;
      frz   <= (state_n != PLAY);
    end
  end

  always_comb begin
    state_n = state;
    s1_n    = s1;
    s2_n    = s2;
    win_n   = win;
    cnt_n   = cnt;
    hits_n  = hits;
    rr_n    = 1'b0;
    rs1_n   = 1'b0;
    rs2_n   = 1'b0;
    // hit on tank 1 scores for tank 2 and vice versa
    up1     = s1 + {3'b000, hit2};
    up2     = s2 + {3'b000, hit1};
    done1   = (up1 == WS);
    done2   = (up2 == WS);
    unique case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n = PLAY;
          s1_n    = '0;
          s2_n    = '0;
          win_n   = WIN_NONE;
          rr_n    = 1'b1;
        end
      end
      PLAY: begin
        if (hit1 | hit2) begin
          s1_n = up1;
          s2_n = up2;
          if (done1 | done2) begin
            state_n = OVER;
            win_n   = winner_of(done1, done2);
          end else begin
            state_n = RESPAWN;
            cnt_n   = '0;
            hits_n  = {hit2, hit1};
          end
        end
      end
      RESPAWN: begin
        if (cnt == RF_LAST) begin
          state_n = PLAY;
          rs1_n   = hits[0];
          rs2_n   = hits[1];
          hits_n  = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.game_state    = state;
  assign bus.score1        = s1;
  assign bus.score2        = s2;
  assign bus.winner        = win;
  assign bus.tanks_freeze  = frz;
  assign bus.tank1_respawn = rs1;
  assign bus.tank2_respawn = rs2;
  assign bus.round_reset   = rr;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed stimulus, a frame-level
// game model checked every cycle, plus literal spot checks.
module tb_game_round_ctrl;

  localparam int WS = 5;
  localparam int RF = 8;
  localparam logic [7:0] SK = 8'h28;

  logic frame_clk = 1'b0;
  logic Reset;

  game_round_ctrl_if bus();

  game_round_ctrl #(
    .WIN_SCORE(WS),
    .RESPAWN_FRAMES(RF),
    .START_KEY(SK)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_tot = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  int m_mode, m_s1, m_s2, m_win, m_left;
  bit m_rec1, m_rec2, m_rr, m_r1, m_r2;
  bit p_k, p_1, p_2;

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Game rules per frame: mode 0 idle, 1 play, 2 frozen, 3 over
  task automatic model_step();
    bit st, h1, h2;
    st = (bus.keycode == SK) && !p_k;
    h1 = bus.Bullet2_Tank1_intersect && !p_1;
    h2 = bus.Bullet1_Tank2_intersect && !p_2;
    p_k = (bus.keycode == SK);
    p_1 = bus.Bullet2_Tank1_intersect;
    p_2 = bus.Bullet1_Tank2_intersect;
    m_rr = 0;
    m_r1 = 0;
    m_r2 = 0;
    if (Reset) begin
      m_mode = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_left = 0; m_rec1 = 0; m_rec2 = 0;
    end else if ((m_mode == 0 || m_mode == 3) && st) begin
      m_mode = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_rr = 1;
    end else if (m_mode == 1 && (h1 || h2)) begin
      if (h1) m_s2 = m_s2 + 1;
      if (h2) m_s1 = m_s1 + 1;
      if (m_s1 == WS || m_s2 == WS) begin
        m_mode = 3;
        m_win = (m_s1 == WS ? 1 : 0) + (m_s2 == WS ? 2 : 0);
      end else begin
        m_mode = 2; m_left = RF; m_rec1 = h1; m_rec2 = h2;
      end
    end else if (m_mode == 2) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode = 1; m_r1 = m_rec1; m_r2 = m_rec2;
      end
    end
  endtask

  initial forever begin
    @(posedge frame_clk);
    model_step();
  end

  initial forever begin
    @(negedge frame_clk);
    if (chk_en) begin
      chk("m_state", int'(bus.game_state), m_mode);
      chk("m_score1", int'(bus.score1), m_s1);
      chk("m_score2", int'(bus.score2), m_s2);
      chk("m_winner", int'(bus.winner), m_win);
      chk("m_freeze", int'(bus.tanks_freeze), int'(m_mode != 1));
      chk("m_resp1", int'(bus.tank1_respawn), int'(m_r1));
      chk("m_resp2", int'(bus.tank2_respawn), int'(m_r2));
      chk("m_rreset", int'(bus.round_reset), int'(m_rr));
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic hit(bit a, bit b);
    bus.Bullet2_Tank1_intersect = a;
    bus.Bullet1_Tank2_intersect = b;
    tick(1);
    bus.Bullet2_Tank1_intersect = 1'b0;
    bus.Bullet1_Tank2_intersect = 1'b0;
    tick(RF + 1);
  endtask

  initial begin
    bus.keycode = 8'h00;
    bus.Bullet2_Tank1_intersect = 1'b0;
    bus.Bullet1_Tank2_intersect = 1'b0;
    Reset = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("rst_state", int'(bus.game_state), 0);
    chk("rst_freeze", int'(bus.tanks_freeze), 1);
    chk("rst_winner", int'(bus.winner), 0);

    // start key held 3 frames gives one round_reset
    bus.keycode = SK;
    tick(1);
    chk("start_state", int'(bus.game_state), 1);
    chk("start_rr", int'(bus.round_reset), 1);
    chk("start_freeze", int'(bus.tanks_freeze), 0);
    tick(1);
    chk("start_rr_once", int'(bus.round_reset), 0);
    tick(1);
    bus.keycode = 8'h00;
    tick(1);

    // tank 1 hit, level held 5 frames
    bus.Bullet2_Tank1_intersect = 1'b1;
    tick(1);
    chk("h1_score2", int'(bus.score2), 1);
    chk("h1_state", int'(bus.game_state), 2);
    tick(4);
    bus.Bullet2_Tank1_intersect = 1'b0;
    tick(3);
    chk("h1_last_frz", int'(bus.game_state), 2);
    tick(1);
    chk("h1_back", int'(bus.game_state), 1);
    chk("h1_resp1", int'(bus.tank1_respawn), 1);
    chk("h1_resp2", int'(bus.tank2_respawn), 0);
    tick(1);
    chk("h1_resp1_off", int'(bus.tank1_respawn), 0);
    chk("h1_score2_once", int'(bus.score2), 1);

    // start ignored during play
    bus.keycode = SK;
    tick(2);
    bus.keycode = 8'h00;
    tick(1);
    chk("play_start_ign", int'(bus.game_state), 1);

    // edge during respawn is ignored, timing unchanged
    bus.Bullet1_Tank2_intersect = 1'b1;
    tick(1);
    bus.Bullet1_Tank2_intersect = 1'b0;
    tick(2);
    bus.Bullet1_Tank2_intersect = 1'b1;
    tick(1);
    bus.Bullet1_Tank2_intersect = 1'b0;
    chk("rsp_ign_s1", int'(bus.score1), 1);
    tick(4);
    chk("rsp_ign_st", int'(bus.game_state), 2);
    tick(1);
    chk("rsp_ign_back", int'(bus.game_state), 1);
    chk("rsp_ign_r2", int'(bus.tank2_respawn), 1);
    tick(1);

    for (int i = 0; i < 3; i++) hit(1'b0, 1'b1);
    chk("s1_four", int'(bus.score1), 4);

    // tank 1 reaches the winning score
    bus.Bullet1_Tank2_intersect = 1'b1;
    tick(1);
    bus.Bullet1_Tank2_intersect = 1'b0;
    chk("win1_s1", int'(bus.score1), 5);
    chk("win1_state", int'(bus.game_state), 3);
    chk("win1_winner", int'(bus.winner), 1);
    tick(1);
    bus.Bullet1_Tank2_intersect = 1'b1;
    tick(1);
    bus.Bullet1_Tank2_intersect = 1'b0;
    tick(1);
    chk("win1_hold", int'(bus.score1), 5);

    // restart from game over
    bus.keycode = SK;
    tick(1);
    bus.keycode = 8'h00;
    chk("rst_over_s1", int'(bus.score1), 0);
    chk("rst_over_win", int'(bus.winner), 0);
    chk("rst_over_rr", int'(bus.round_reset), 1);
    chk("rst_over_st", int'(bus.game_state), 1);
    tick(1);

    // simultaneous hits up to a draw
    for (int i = 0; i < 4; i++) hit(1'b1, 1'b1);
    chk("draw_pre_s2", int'(bus.score2), 4);
    bus.Bullet2_Tank1_intersect = 1'b1;
    bus.Bullet1_Tank2_intersect = 1'b1;
    tick(1);
    bus.Bullet2_Tank1_intersect = 1'b0;
    bus.Bullet1_Tank2_intersect = 1'b0;
    chk("draw_s1", int'(bus.score1), 5);
    chk("draw_s2", int'(bus.score2), 5);
    chk("draw_win", int'(bus.winner), 3);
    chk("draw_state", int'(bus.game_state), 3);
    tick(RF + 2);
    chk("draw_stay", int'(bus.game_state), 3);

    // key already held through reset is not a start
    bus.keycode = SK;
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(2);
    chk("held_key", int'(bus.game_state), 0);
    bus.keycode = 8'h00;
    tick(1);

    // reset in the middle of a respawn
    bus.keycode = SK;
    tick(1);
    bus.keycode = 8'h00;
    tick(1);
    bus.Bullet2_Tank1_intersect = 1'b1;
    tick(1);
    tick(3);
    Reset = 1'b1;
    bus.Bullet2_Tank1_intersect = 1'b0;
    tick(1);
    chk("mid_rst_st", int'(bus.game_state), 0);
    chk("mid_rst_s2", int'(bus.score2), 0);
    Reset = 1'b0;
    tick(RF + 3);
    chk("mid_rst_idle", int'(bus.game_state), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5, is the score that ends a game (range 1..15).
REQ-002 Parameter RESPAWN_FRAMES, default 8, is the number of frames both tanks are frozen after a hit (range 1..255).
REQ-003 Parameter START_KEY, default 8'h28, is the keycode that starts a game.
REQ-004 frame_clk  in  1  frame-rate clock; the block's only clock.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 keycode  in  8  current keyboard keycode.
REQ-007 Bullet2_Tank1_intersect  in  1  level: tank 2's bullet overlaps tank 1.
REQ-008 Bullet1_Tank2_intersect  in  1  level: tank 1's bullet overlaps tank 2.
REQ-009 game_state  out  2  current FSM state encoding.
REQ-010 score1, score2  out  4 each  points for tank 1 and tank 2.
REQ-011 winner  out  2  00 none, 01 tank 1, 10 tank 2, 11 draw.
REQ-012 tanks_freeze  out  1  high: tank movement and firing are suppressed.
REQ-013 tank1_respawn, tank2_respawn  out  1 each  one-cycle pulse: return that tank to its spawn point.
REQ-014 round_reset  out  1  one-cycle pulse: respawn both tanks and clear bullets at game start.

Function
REQ-015 The FSM SHALL have states IDLE=0, PLAY=1, RESPAWN=2, OVER=3, output on game_state.
REQ-016 Start event SHALL be keycode==START_KEY this cycle and !=START_KEY the previous cycle.
REQ-017 Hit event for each tank SHALL be a 0->1 transition of its intersect input.
REQ-018 A level held high SHALL NOT produce repeated events.
REQ-019 IDLE + start event: next state PLAY; score1, score2 and winner cleared; round_reset high for that next cycle only.
REQ-020 OVER + start event: identical behaviour to REQ-019.
REQ-021 PLAY + hit on tank 1: score2 +1 in the next cycle.
REQ-022 PLAY + hit on tank 2: score1 +1 in the next cycle.
REQ-023 Simultaneous hits in PLAY SHALL increment both scores in the same cycle.
REQ-024 After a PLAY hit, if any updated score equals WIN_SCORE, next state SHALL be OVER; winner is 01, 10 or 11 (both reached it).
REQ-025 After a PLAY hit where neither score reaches WIN_SCORE, next state SHALL be RESPAWN.
REQ-026 Entering RESPAWN SHALL load a frame counter with 0 and record which tank(s) were hit.
REQ-027 The counter SHALL increment once per cycle while in RESPAWN.
REQ-028 RESPAWN SHALL exit to PLAY on the cycle the counter equals RESPAWN_FRAMES-1, giving RESPAWN_FRAMES cycles in RESPAWN.
REQ-029 The respawn pulse of each recorded tank SHALL be high for exactly the first PLAY cycle after RESPAWN.
REQ-030 Hit events in IDLE, RESPAWN and OVER SHALL be ignored, with no score change.
REQ-031 Start events in PLAY and RESPAWN SHALL be ignored.
REQ-032 tanks_freeze SHALL be high in IDLE, RESPAWN and OVER, and low in PLAY.
REQ-033 All outputs SHALL be registered; scores SHALL never exceed WIN_SCORE.

Reset
REQ-034 While Reset is high at a frame_clk edge:
- state := IDLE
- scores := 0, winner := 00
- counter := 0, recorded hits := 0
- pulses := 0, tanks_freeze := 1
- edge-detect history := current input values, so a key or intersect already high is not an event after reset
REQ-035 Reset mid-RESPAWN or mid-OVER SHALL abandon the operation with no respawn pulse issued.

Structure
REQ-036 A shared package game_pkg SHALL hold:
- the state enum type
- the winner encodings
- START_KEY default
- WIN_SCORE and RESPAWN_FRAMES defaults
REQ-037 Edge detection SHALL use one reusable sub-module, rise_detect, instantiated three times: start, hit1, hit2.

Verification
REQ-038 Reset, keycode 8'h28 for 3 cycles -> one round_reset pulse, game_state 1, tanks_freeze 0, scores 0.
REQ-039 PLAY, Bullet2_Tank1_intersect high for 5 cycles -> score2=1 once, state 2 for 8 cycles, then state 1 with tank1_respawn high 1 cycle, tank2_respawn low.
REQ-040 PLAY, both intersects rise in the same cycle with scores 4/4 -> scores 5/5, state 3, winner 11, no respawn pulses.
REQ-041 score1=4, Bullet1_Tank2_intersect rises -> score1=5, state 3, winner 01; a further intersect edge leaves the score at 5.
REQ-042 Intersect edge during RESPAWN -> no score change and timing unchanged; Reset asserted at counter=3 -> IDLE, no respawn pulse.
REQ-043 OVER, press 8'h28 -> scores 0, winner 00, round_reset pulse, state 1.
